// File: rtl/mult_axil_pkg.sv
// Shared definitions for the AXI4-Lite multiplier slave: register word
// indices, CTRL bit positions, response codes, core FSM states and helpers.
package mult_axil_pkg;

    localparam int DATA_W = 32;

    // Register word indices (byte address bits [4:2])
    localparam logic [2:0] REG_OP_A   = 3'd0;
    localparam logic [2:0] REG_OP_B   = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_RES_LO = 3'd3;
    localparam logic [2:0] REG_RES_HI = 3'd4;

    // CTRL bit positions
    localparam int CTRL_START = 0;
    localparam int CTRL_IE    = 1;
    localparam int CTRL_BUSY  = 8;
    localparam int CTRL_DONE  = 9;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Multiplier core states; ST_DONE is idle with the sticky DONE flag set
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

    // Byte-lane merge of write data into an existing register value
    function automatic logic [DATA_W-1:0] apply_wstrb(
        input logic [DATA_W-1:0]   old_val,
        input logic [DATA_W-1:0]   wdata,
        input logic [DATA_W/8-1:0] wstrb
    );
        logic [DATA_W-1:0] merged;
        merged = old_val;
        for (int i = 0; i < DATA_W/8; i++) begin
            if (wstrb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
        return merged;
    endfunction

    // Assemble the CTRL read-back word; START always reads as 0
    function automatic logic [DATA_W-1:0] ctrl_word(
        input logic ie,
        input logic busy,
        input logic done
    );
        logic [DATA_W-1:0] word;
        word            = '0;
        word[CTRL_IE]   = ie;
        word[CTRL_BUSY] = busy;
        word[CTRL_DONE] = done;
        return word;
    endfunction

endpackage

// File: rtl/mult_seq_core.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per cycle,
// WIDTH cycles per product. The product register only changes on completion,
// so it doubles as the RES_LO/RES_HI storage.
module mult_seq_core
    import mult_axil_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    mult_state_e        r_state;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_product;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Core FSM: latch operands on start, shift-add for WIDTH cycles, hold result
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, i_a};
                        r_mplier <= i_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST_STEP) begin
                        r_product <= w_acc_next;
                        r_state   <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy    = (r_state == ST_RUN);
    assign o_done    = (r_state == ST_DONE);
    assign o_product = r_product;

endmodule

// File: rtl/mult_axil_slave.sv
// AXI4-Lite slave register file in front of the sequential multiplier.
// AW and W are latched independently; the register write commits the cycle
// after both are held, together with BVALID. Reads are single-beat with
// registered RDATA/RRESP.
module mult_axil_slave
    import mult_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            IRQ
);

    localparam int DW = C_S_AXI_DATA_WIDTH;

    // Write channel state
    logic                 r_awready, r_wready, r_bvalid;
    logic                 r_aw_full, r_w_full;
    logic [1:0]           r_bresp;
    logic [2:0]           r_aw_idx;
    logic [DW-1:0]        r_wdata;
    logic [DW/8-1:0]      r_wstrb;
    logic                 w_aw_hs, w_w_hs, w_commit;
    logic                 w_aw_full_next, w_w_full_next, w_bvalid_next;
    logic [1:0]           w_wr_resp;

    // Read channel state
    logic                 r_arready, r_rvalid;
    logic [DW-1:0]        r_rdata;
    logic [1:0]           r_rresp;
    logic                 w_ar_hs, w_rvalid_next;
    logic [DW-1:0]        w_rd_data;
    logic [1:0]           w_rd_resp;

    // Register file and core interface
    logic [DW-1:0]        r_op_a, r_op_b;
    logic                 r_ie, r_start;
    logic                 w_busy, w_done;
    logic [2*DW-1:0]      w_product;

    // Protection bits and byte-offset bits carry no meaning for this slave
    logic                 w_unused;
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign w_aw_hs        = S_AXI_AWVALID && r_awready;
    assign w_w_hs         = S_AXI_WVALID && r_wready;
    assign w_commit       = r_aw_full && r_w_full;
    assign w_aw_full_next = (r_aw_full || w_aw_hs) && !w_commit;
    assign w_w_full_next  = (r_w_full || w_w_hs) && !w_commit;
    assign w_bvalid_next  = w_commit || (r_bvalid && !S_AXI_BREADY);
    assign w_wr_resp      = (r_aw_idx <= REG_RES_HI) ? RESP_OKAY : RESP_SLVERR;

    // Write handshake: hold AW/W until commit, then hold B until BREADY
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_aw_full <= w_aw_full_next;
            r_w_full  <= w_w_full_next;
            r_bvalid  <= w_bvalid_next;
            r_awready <= !w_aw_full_next && !w_bvalid_next;
            r_wready  <= !w_w_full_next && !w_bvalid_next;
            if (w_aw_hs) r_aw_idx <= S_AXI_AWADDR[4:2];
            if (w_w_hs) begin
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end
            if (w_commit) r_bresp <= w_wr_resp;
        end
    end

    // Register file update on commit; START becomes a one-cycle pulse to the core
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_ie    <= 1'b0;
            r_start <= 1'b0;
        end else begin
            r_start <= 1'b0;
            if (w_commit) begin
                case (r_aw_idx)
                    REG_OP_A: r_op_a <= apply_wstrb(r_op_a, r_wdata, r_wstrb);
                    REG_OP_B: r_op_b <= apply_wstrb(r_op_b, r_wdata, r_wstrb);
                    REG_CTRL: begin
                        if (r_wstrb[0]) begin
                            r_ie    <= r_wdata[CTRL_IE];
                            r_start <= r_wdata[CTRL_START];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_ar_hs       = S_AXI_ARVALID && r_arready;
    assign w_rvalid_next = w_ar_hs || (r_rvalid && !S_AXI_RREADY);

    // Read decode from the current (pre-commit) register values
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        case (S_AXI_ARADDR[4:2])
            REG_OP_A:   w_rd_data = r_op_a;
            REG_OP_B:   w_rd_data = r_op_b;
            REG_CTRL:   w_rd_data = ctrl_word(r_ie, w_busy, w_done);
            REG_RES_LO: w_rd_data = w_product[DW-1:0];
            REG_RES_HI: w_rd_data = w_product[2*DW-1:DW];
            default:    w_rd_resp = RESP_SLVERR;
        endcase
    end

    // Read handshake: register the beat on AR acceptance, hold until RREADY
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_rvalid  <= w_rvalid_next;
            r_arready <= !w_rvalid_next;
            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_resp;
            end
        end
    end

    mult_seq_core #(
        .WIDTH     (DW)
    ) u_core (
        .i_clk     (ACLK),
        .i_rst     (ARESET),
        .i_start   (r_start),
        .i_a       (r_op_a),
        .i_b       (r_op_b),
        .o_busy    (w_busy),
        .o_done    (w_done),
        .o_product (w_product)
    );

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign IRQ           = w_done && r_ie;

endmodule
